// File: rtl/reg_scoreboard.sv
`default_nettype none
// ============================================================================
// Module   : reg_scoreboard
// Purpose  : Issue-stage register scoreboard. Keeps one pending-write counter
//            per architectural register (x1..x31). Holds issue back on RAW
//            hazards and when the destination counter is saturated. Writes
//            retiring at WB release the hazard.
// Revision : 1.0  initial release
// ============================================================================
module reg_scoreboard #(
    parameter int REG_ADDRW = 5,
    parameter int CNT_W     = 2,
    parameter bit WB_BYPASS = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 id_valid,
    input  logic [REG_ADDRW-1:0] id_rs1id,
    input  logic [REG_ADDRW-1:0] id_rs2id,
    input  logic [REG_ADDRW-1:0] id_rdid,
    input  logic                 id_rdwen,
    output logic                 id_ready,
    output logic                 ex_valid,
    input  logic                 ex_ready,
    input  logic                 wb_valid,
    input  logic [REG_ADDRW-1:0] wb_rdid,
    input  logic                 flush,
    output logic                 busy_any,
    output logic                 sb_err
);

    localparam int               NREG     = 1 << REG_ADDRW;
    localparam logic [CNT_W-1:0] CNT_ZERO = '0;
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam logic [REG_ADDRW-1:0] REG_X0 = '0;

    // Pending-write counters; entry 0 is held at zero so x0 is never pending.
    logic [CNT_W-1:0] cnt_q [NREG];
    logic [CNT_W-1:0] cnt_d [NREG];
    logic             sb_err_q;
    logic             sb_err_d;

    logic [CNT_W-1:0] cnt_rs1;
    logic [CNT_W-1:0] cnt_rs2;
    logic [CNT_W-1:0] cnt_rd;
    logic [CNT_W-1:0] cnt_wb;
    logic             byp_rs1;
    logic             byp_rs2;
    logic             pend_rs1;
    logic             pend_rs2;
    logic             raw;
    logic             waw_full;
    logic             hazard;
    logic             issue;
    logic             busy;

    // Hazard detection. A source whose only outstanding write retires this
    // cycle may be released early when the WB bypass is enabled; the
    // saturation check never takes the bypass so a counter cannot overflow.
    always_comb begin
        cnt_rs1  = cnt_q[id_rs1id];
        cnt_rs2  = cnt_q[id_rs2id];
        cnt_rd   = cnt_q[id_rdid];
        byp_rs1  = WB_BYPASS && wb_valid && (wb_rdid == id_rs1id) && (cnt_rs1 == CNT_ONE);
        byp_rs2  = WB_BYPASS && wb_valid && (wb_rdid == id_rs2id) && (cnt_rs2 == CNT_ONE);
        pend_rs1 = (id_rs1id != REG_X0) && (cnt_rs1 != CNT_ZERO) && !byp_rs1;
        pend_rs2 = (id_rs2id != REG_X0) && (cnt_rs2 != CNT_ZERO) && !byp_rs2;
        raw      = pend_rs1 || pend_rs2;
        waw_full = id_rdwen && (id_rdid != REG_X0) && (cnt_rd == CNT_MAX);
        hazard   = raw || waw_full;
    end

    assign id_ready = ex_ready && !hazard && !flush;
    assign ex_valid = id_valid && !hazard && !flush;
    assign issue    = id_valid && id_ready;

    // Drain indication: any register with an outstanding write.
    always_comb begin
        busy = 1'b0;
        for (int r = 1; r < NREG; r++) begin
            if (cnt_q[r] != CNT_ZERO) begin
                busy = 1'b1;
            end
        end
    end

    assign busy_any = busy;
    assign sb_err   = sb_err_q;

    // Counter next-state: +1 on issue to rd, -1 on WB retire, unchanged when
    // both hit the same register. A flush discards everything in flight,
    // including the issue and WB presented in the flush cycle.
    always_comb begin
        cnt_wb   = cnt_q[wb_rdid];
        sb_err_d = sb_err_q;
        cnt_d[0] = CNT_ZERO;
        for (int r = 1; r < NREG; r++) begin
            cnt_d[r] = cnt_q[r];
            if (flush) begin
                cnt_d[r] = CNT_ZERO;
            end else if (issue && id_rdwen && (id_rdid == REG_ADDRW'(r))) begin
                if (!(wb_valid && (wb_rdid == REG_ADDRW'(r)) && (cnt_q[r] != CNT_ZERO))) begin
                    cnt_d[r] = cnt_q[r] + CNT_ONE;
                end
            end else if (wb_valid && (wb_rdid == REG_ADDRW'(r)) && (cnt_q[r] != CNT_ZERO)) begin
                cnt_d[r] = cnt_q[r] - CNT_ONE;
            end
        end
        // A retire for a register with nothing outstanding is a protocol error.
        if (!flush && wb_valid && (wb_rdid != REG_X0) && (cnt_wb == CNT_ZERO)) begin
            sb_err_d = 1'b1;
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int r = 0; r < NREG; r++) begin
                cnt_q[r] <= CNT_ZERO;
            end
            sb_err_q <= 1'b0;
        end else begin
            for (int r = 0; r < NREG; r++) begin
                cnt_q[r] <= cnt_d[r];
            end
            sb_err_q <= sb_err_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_reg_scoreboard.sv
`default_nettype none
// ============================================================================
// Module   : tb_reg_scoreboard
// Purpose  : Self-checking bench for reg_scoreboard. One instance with the WB
//            bypass enabled and one without share the same stimulus.
// Revision : 1.0  initial release
// ============================================================================
module tb_reg_scoreboard;

    logic       clk;
    logic       rst;
    logic       id_valid;
    logic [4:0] id_rs1id;
    logic [4:0] id_rs2id;
    logic [4:0] id_rdid;
    logic       id_rdwen;
    logic       ex_ready;
    logic       wb_valid;
    logic [4:0] wb_rdid;
    logic       flush;

    logic       id_ready,    ex_valid,    busy_any,    sb_err;
    logic       id_ready_nb, ex_valid_nb, busy_any_nb, sb_err_nb;

    int n_pass  = 0;
    int n_total = 0;

    typedef struct {
        logic       rst, flush, vld;
        logic [4:0] rs1, rs2, rd;
        logic       wen, exr, wbv;
        logic [4:0] wbr;
        logic       e_rdy, e_exv, e_rdy_nb, e_exv_nb, e_busy, e_err;
    } vec_t;

    vec_t vecs[$];
    vec_t exp_q[$];

    reg_scoreboard #(.REG_ADDRW(5), .CNT_W(2), .WB_BYPASS(1'b1)) dut (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs1id(id_rs1id),
        .id_rs2id(id_rs2id), .id_rdid(id_rdid), .id_rdwen(id_rdwen),
        .id_ready(id_ready), .ex_valid(ex_valid), .ex_ready(ex_ready),
        .wb_valid(wb_valid), .wb_rdid(wb_rdid), .flush(flush),
        .busy_any(busy_any), .sb_err(sb_err)
    );

    reg_scoreboard #(.REG_ADDRW(5), .CNT_W(2), .WB_BYPASS(1'b0)) dut_nb (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs1id(id_rs1id),
        .id_rs2id(id_rs2id), .id_rdid(id_rdid), .id_rdwen(id_rdwen),
        .id_ready(id_ready_nb), .ex_valid(ex_valid_nb), .ex_ready(ex_ready),
        .wb_valid(wb_valid), .wb_rdid(wb_rdid), .flush(flush),
        .busy_any(busy_any_nb), .sb_err(sb_err_nb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string nm, input int idx, input logic act, input logic exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s step %0d: got %b expected %b", nm, idx, act, exp);
        end
    endtask

    task automatic add(input int r, input int fl, input int v, input int s1, input int s2,
                       input int d, input int w, input int er, input int wv, input int wr,
                       input int rdy, input int exv, input int rdyn, input int exvn,
                       input int bsy, input int err);
        vec_t t;
        t.rst = r[0]; t.flush = fl[0]; t.vld = v[0];
        t.rs1 = s1[4:0]; t.rs2 = s2[4:0]; t.rd = d[4:0];
        t.wen = w[0]; t.exr = er[0]; t.wbv = wv[0]; t.wbr = wr[4:0];
        t.e_rdy = rdy[0]; t.e_exv = exv[0]; t.e_rdy_nb = rdyn[0]; t.e_exv_nb = exvn[0];
        t.e_busy = bsy[0]; t.e_err = err[0];
        vecs.push_back(t);
    endtask

    task automatic drive(input vec_t t);
        rst = t.rst; flush = t.flush; id_valid = t.vld;
        id_rs1id = t.rs1; id_rs2id = t.rs2; id_rdid = t.rd; id_rdwen = t.wen;
        ex_ready = t.exr; wb_valid = t.wbv; wb_rdid = t.wbr;
    endtask

    task automatic set_in(input int v, input int s1, input int d, input int w,
                          input int wv, input int wr);
        rst = 1'b0; flush = 1'b0; ex_ready = 1'b1;
        id_valid = v[0]; id_rs1id = s1[4:0]; id_rs2id = 5'd0;
        id_rdid = d[4:0]; id_rdwen = w[0]; wb_valid = wv[0]; wb_rdid = wr[4:0];
    endtask

    initial begin
        vec_t e;
        int   cyc;
        logic got;

        rst = 1'b1; flush = 1'b0; id_valid = 1'b0; id_rs1id = '0; id_rs2id = '0;
        id_rdid = '0; id_rdwen = 1'b0; ex_ready = 1'b1; wb_valid = 1'b0; wb_rdid = '0;
        repeat (2) @(posedge clk);

        //   rst fl vld rs1 rs2 rd wen exr wbv wbr | rdy exv rdyn exvn busy err
        add(1, 0, 0,  0,  0,  0, 0, 1, 0,  0,   1, 0, 1, 0, 0, 0); // reset state
        // RAW on x5, released by WB
        add(0, 0, 1,  0,  0,  5, 1, 1, 0,  0,   1, 1, 1, 1, 0, 0);
        add(0, 0, 1,  5,  0,  0, 0, 1, 0,  0,   0, 0, 0, 0, 1, 0);
        add(0, 0, 1,  0,  5,  0, 0, 1, 0,  0,   0, 0, 0, 0, 1, 0);
        add(0, 0, 1,  5,  0,  0, 0, 1, 1,  5,   1, 1, 0, 0, 1, 0);
        add(0, 0, 1,  5,  0,  0, 0, 1, 0,  0,   1, 1, 1, 1, 0, 0);
        // saturation on x7
        add(0, 0, 1,  0,  0,  7, 1, 1, 0,  0,   1, 1, 1, 1, 0, 0);
        add(0, 0, 1,  0,  0,  7, 1, 1, 0,  0,   1, 1, 1, 1, 1, 0);
        add(0, 0, 1,  0,  0,  7, 1, 1, 0,  0,   1, 1, 1, 1, 1, 0);
        add(0, 0, 1,  0,  0,  7, 1, 1, 0,  0,   0, 0, 0, 0, 1, 0);
        add(0, 0, 1,  0,  0,  7, 1, 1, 1,  7,   0, 0, 0, 0, 1, 0);
        add(0, 0, 1,  0,  0,  7, 1, 1, 0,  0,   1, 1, 1, 1, 1, 0);
        add(0, 0, 1,  0,  0,  7, 1, 1, 0,  0,   0, 0, 0, 0, 1, 0);
        add(0, 0, 0,  0,  0,  0, 0, 1, 1,  7,   1, 0, 1, 0, 1, 0);
        add(0, 0, 0,  0,  0,  0, 0, 1, 1,  7,   1, 0, 1, 0, 1, 0);
        add(0, 0, 0,  0,  0,  0, 0, 1, 1,  7,   1, 0, 1, 0, 1, 0);
        add(0, 0, 0,  0,  0,  0, 0, 1, 0,  0,   1, 0, 1, 0, 0, 0);
        // simultaneous issue and retire on x9
        add(0, 0, 1,  0,  0,  9, 1, 1, 0,  0,   1, 1, 1, 1, 0, 0);
        add(0, 0, 1,  0,  0,  9, 1, 1, 1,  9,   1, 1, 1, 1, 1, 0);
        add(0, 0, 1,  9,  0,  0, 0, 1, 0,  0,   0, 0, 0, 0, 1, 0);
        add(0, 0, 0,  0,  0,  0, 0, 1, 1,  9,   1, 0, 1, 0, 1, 0);
        // flush with x3, x4 pending
        add(0, 0, 1,  0,  0,  3, 1, 1, 0,  0,   1, 1, 1, 1, 0, 0);
        add(0, 0, 1,  0,  0,  4, 1, 1, 0,  0,   1, 1, 1, 1, 1, 0);
        add(0, 1, 1,  0,  0,  5, 1, 1, 1,  3,   0, 0, 0, 0, 1, 0);
        add(0, 0, 1,  3,  4,  0, 0, 1, 0,  0,   1, 1, 1, 1, 0, 0);
        // spurious retire sets the sticky error; x0 retire ignored
        add(0, 0, 0,  0,  0,  0, 0, 1, 1, 12,   1, 0, 1, 0, 0, 0);
        add(0, 0, 0,  0,  0,  0, 0, 1, 0,  0,   1, 0, 1, 0, 0, 1);
        add(0, 0, 0,  0,  0,  0, 0, 1, 1,  0,   1, 0, 1, 0, 0, 1);
        add(0, 0, 0,  0,  0,  0, 0, 1, 0,  0,   1, 0, 1, 0, 0, 1);
        // x0 everywhere never stalls and never counts
        add(0, 0, 1,  0,  0,  0, 1, 1, 0,  0,   1, 1, 1, 1, 0, 1);
        add(0, 0, 1,  0,  0,  0, 1, 1, 0,  0,   1, 1, 1, 1, 0, 1);
        add(0, 0, 1,  0,  0,  0, 1, 1, 0,  0,   1, 1, 1, 1, 0, 1);
        // EX back-pressure
        add(0, 0, 0,  0,  0,  0, 0, 0, 0,  0,   0, 0, 0, 0, 0, 1);
        // reset in the middle of operation
        add(0, 0, 1,  0,  0,  6, 1, 1, 0,  0,   1, 1, 1, 1, 0, 1);
        add(1, 0, 0,  0,  0,  0, 0, 1, 0,  0,   1, 0, 1, 0, 1, 1);
        add(0, 0, 1,  6,  0,  0, 0, 1, 0,  0,   1, 1, 1, 1, 0, 0);

        foreach (vecs[i]) begin
            @(posedge clk);
            #1;
            drive(vecs[i]);
            exp_q.push_back(vecs[i]);
            #3;
            e = exp_q.pop_front();
            check("id_ready",       i, id_ready,    e.e_rdy);
            check("ex_valid",       i, ex_valid,    e.e_exv);
            check("id_ready_nobyp", i, id_ready_nb, e.e_rdy_nb);
            check("ex_valid_nobyp", i, ex_valid_nb, e.e_exv_nb);
            check("busy_any",       i, busy_any,    e.e_busy);
            check("sb_err",         i, sb_err,      e.e_err);
            check("busy_any_nobyp", i, busy_any_nb, e.e_busy);
            check("sb_err_nobyp",   i, sb_err_nb,   e.e_err);
        end

        // Saturate x31, then hold a reader of x31 while three writes retire.
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            set_in(1, 0, 31, 1, 0, 0);
            #3;
            check("x31_fill_ready", k, id_ready, 1'b1);
        end
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            set_in(1, 31, 0, 0, 1, 31);
            #3;
            check("x31_drain_ready",       k, id_ready,    (k == 2));
            check("x31_drain_ready_nobyp", k, id_ready_nb, 1'b0);
        end
        @(posedge clk); #1;
        set_in(1, 31, 0, 0, 0, 0);
        #3;
        check("x31_after_ready_nobyp", 0, id_ready_nb, 1'b1);
        check("x31_after_busy",        0, busy_any,    1'b0);

        // Bounded wait: a single write to x20 must leave busy_any set until
        // it retires, then clear within a couple of cycles.
        @(posedge clk); #1;
        set_in(1, 0, 20, 1, 0, 0);
        @(posedge clk); #1;
        set_in(0, 0, 0, 0, 1, 20);
        got = 1'b0;
        cyc = 0;
        while (!got && cyc < 8) begin
            @(posedge clk); #1;
            set_in(0, 0, 0, 0, 0, 0);
            #3;
            got = !busy_any;
            cyc++;
        end
        check("x20_drain_timeout", cyc, got, 1'b1);
        check("x20_sb_err",        cyc, sb_err, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
